// File: rtl/ntt_host_sequencer.sv
// Job-level initiator for the NTT core: loads one polynomial, runs one instruction,
// and streams one polynomial back through a small credit-gated read FIFO.
module ntt_host_sequencer #(
  parameter int LOGN        = 10,
  parameter int LOGQ        = 32,
  parameter int LOG_POLY    = 2,
  parameter int RD_LAT      = 2,
  parameter int LOG_COMMAND = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [31:0]            job_cfg,
  input  logic [LOGQ-1:0]        job_q,
  input  logic [LOGQ-1:0]        job_mont,
  input  logic                   job_load_en,
  input  logic                   job_unload_en,
  input  logic [LOG_POLY-1:0]    job_load_poly,
  input  logic [LOG_POLY-1:0]    job_unload_poly,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LOGQ-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LOGQ-1:0]        out_data,
  output logic                   busy,
  output logic [19:0]            address_ext,
  output logic [63:0]            dina_ext,
  output logic [31:0]            dina2_ext,
  output logic [63:0]            dina3_ext,
  output logic                   wea_ext,
  input  logic [63:0]            doutb_ext,
  output logic [LOG_COMMAND-1:0] command_in,
  output logic                   command_we,
  input  logic                   done_ins_computation,
  output logic                   grant_ext_io
);

  localparam int N     = 1 << LOGN;
  localparam int AW    = LOG_POLY + LOGN;
  localparam int DEPTH = RD_LAT + 1;
  localparam int CW    = $clog2(DEPTH + RD_LAT + 1);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_RUN, S_WAIT, S_DISARM, S_UNLOAD, S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [LOGN:0]       idx_q, idx_d;
  logic [31:0]         cfg_q;
  logic [LOGQ-1:0]     modq_q, mont_q;
  logic                unloadEn_q, grant_q;
  logic [LOG_POLY-1:0] loadPoly_q, unloadPoly_q;
  logic [RD_LAT-1:0]   rdPipe_q;
  logic [LOGQ-1:0]     fifoMem_q [DEPTH];
  logic [PW-1:0]       wrPtr_q, rdPtr_q;
  logic [CW-1:0]       count_q, inflight, occupancy;
  logic                accept, loadBeat, issue, push, pop, lastIdx;
  logic [AW-1:0]       addrRaw;
  logic                unusedDoutbHi;

  assign unusedDoutbHi = ^doutb_ext[63:LOGQ];

  assign accept   = job_valid && job_ready;
  assign loadBeat = (state_q == S_LOAD) && in_valid;
  assign lastIdx  = (idx_q == (LOGN+1)'(N - 1));
  assign push     = rdPipe_q[RD_LAT-1];
  assign pop      = out_valid && out_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(rdPipe_q[i]);
  end

  // The word leaving the FIFO this cycle frees its slot, which keeps unload at full rate.
  assign occupancy = count_q + inflight - CW'(pop);
  assign issue     = (state_q == S_UNLOAD) && (occupancy < CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cfg_q        <= '0;
      modq_q       <= '0;
      mont_q       <= '0;
      unloadEn_q   <= 1'b0;
      loadPoly_q   <= '0;
      unloadPoly_q <= '0;
      grant_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= 1'b1;
      if (accept) begin
        cfg_q        <= job_cfg;
        modq_q       <= job_q;
        mont_q       <= job_mont;
        unloadEn_q   <= job_unload_en;
        loadPoly_q   <= job_load_poly;
        unloadPoly_q <= job_unload_poly;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = job_load_en ? S_LOAD : S_ARM;
        idx_d   = '0;
      end
      S_LOAD: if (loadBeat) begin
        idx_d = idx_q + 1'b1;
        if (lastIdx) state_d = S_ARM;
      end
      S_ARM:  state_d = S_RUN;
      S_RUN:  state_d = S_WAIT;
      S_WAIT: if (done_ins_computation) state_d = S_DISARM;
      S_DISARM: begin
        state_d = unloadEn_q ? S_UNLOAD : S_IDLE;
        idx_d   = '0;
      end
      S_UNLOAD: if (issue) begin
        idx_d = idx_q + 1'b1;
        if (lastIdx) state_d = S_DRAIN;
      end
      S_DRAIN: if (inflight == '0 && count_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    job_ready  = (state_q == S_IDLE) && grant_q;
    busy       = (state_q != S_IDLE);
    in_ready   = (state_q == S_LOAD);
    wea_ext    = loadBeat;
    command_we = (state_q == S_RUN) || (state_q == S_DISARM);
    command_in = (state_q == S_RUN) ? LOG_COMMAND'(8'h80) : '0;
    addrRaw    = '0;
    if (state_q == S_LOAD)   addrRaw = {loadPoly_q, idx_q[LOGN-1:0]};
    if (state_q == S_UNLOAD) addrRaw = {unloadPoly_q, idx_q[LOGN-1:0]};
    address_ext = 20'(addrRaw);
    dina_ext    = (state_q == S_LOAD) ? 64'(in_data) : 64'(modq_q);
    dina2_ext   = cfg_q;
    dina3_ext   = 64'(mont_q);
  end

  assign grant_ext_io = grant_q;
  assign out_valid    = (count_q != '0);
  assign out_data     = fifoMem_q[rdPtr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPipe_q <= '0;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
    end else begin
      rdPipe_q[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) rdPipe_q[i] <= rdPipe_q[i-1];
      if (push) wrPtr_q <= (wrPtr_q == PW'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= (rdPtr_q == PW'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= doutb_ext[LOGQ-1:0];
  end

endmodule

// File: tb/tb_ntt_host_sequencer.sv
// Scoreboard bench for ntt_host_sequencer with a behavioural core memory model.
module tb_ntt_host_sequencer;

  localparam int LOGN = 3, LOGQ = 32, LOG_POLY = 2, RD_LAT = 2, LOG_COMMAND = 8;
  localparam int N = 1 << LOGN;

  logic clk, rst_n;
  logic job_valid, job_ready, job_load_en, job_unload_en;
  logic [31:0] job_cfg;
  logic [LOGQ-1:0] job_q, job_mont, in_data, out_data;
  logic [LOG_POLY-1:0] job_load_poly, job_unload_poly;
  logic in_valid, in_ready, out_valid, out_ready, busy, wea_ext, command_we;
  logic done_ins_computation, grant_ext_io;
  logic [19:0] address_ext;
  logic [63:0] dina_ext, dina3_ext, doutb_ext;
  logic [31:0] dina2_ext;
  logic [LOG_COMMAND-1:0] command_in;

  int checks = 0;
  int errors = 0;

  logic [19:0] expWrAddr[$];
  logic [63:0] expWrData[$];
  logic [31:0] expOut[$];
  logic [7:0]  expCmd[$];
  logic [31:0] refMem [0:3][0:N-1];
  logic [63:0] mem [0:(1<<(LOG_POLY+LOGN))-1];
  logic [63:0] rdPipe [0:RD_LAT-1];

  ntt_host_sequencer #(.LOGN(LOGN), .LOGQ(LOGQ), .LOG_POLY(LOG_POLY),
                       .RD_LAT(RD_LAT), .LOG_COMMAND(LOG_COMMAND)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_cfg(job_cfg), .job_q(job_q), .job_mont(job_mont),
    .job_load_en(job_load_en), .job_unload_en(job_unload_en),
    .job_load_poly(job_load_poly), .job_unload_poly(job_unload_poly),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .address_ext(address_ext), .dina_ext(dina_ext),
    .dina2_ext(dina2_ext), .dina3_ext(dina3_ext), .wea_ext(wea_ext),
    .doutb_ext(doutb_ext), .command_in(command_in), .command_we(command_we),
    .done_ins_computation(done_ins_computation), .grant_ext_io(grant_ext_io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core memory: synchronous write, RD_LAT-cycle registered read.
  always @(posedge clk) begin
    if (wea_ext) mem[address_ext[LOG_POLY+LOGN-1:0]] <= dina_ext;
    rdPipe[0] <= mem[address_ext[LOG_POLY+LOGN-1:0]];
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign doutb_ext = rdPipe[RD_LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("[TB] FAIL %s actual=0x%0h required=none", name, act);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, an output word or a command.
  always @(negedge clk) begin
    if (wea_ext) begin
      if (expWrAddr.size() == 0) reportUnexpected("wr_extra", 64'(address_ext));
      else begin
        checkOutput("wr_addr", 64'(address_ext), 64'(expWrAddr.pop_front()));
        checkOutput("wr_data", dina_ext, expWrData.pop_front());
      end
    end
    if (out_valid && out_ready) begin
      if (expOut.size() == 0) reportUnexpected("out_extra", 64'(out_data));
      else checkOutput("out_data", 64'(out_data), 64'(expOut.pop_front()));
    end
    if (command_we) begin
      if (expCmd.size() == 0) reportUnexpected("cmd_extra", 64'(command_in));
      else checkOutput("cmd_in", 64'(command_in), 64'(expCmd.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic ld, input logic ul, input int lp, input int up,
                               input logic [31:0] cfg, input logic [31:0] q, input logic [31:0] mont);
    int k = 0;
    @(posedge clk); #1;
    job_load_en = ld; job_unload_en = ul;
    job_load_poly = LOG_POLY'(lp); job_unload_poly = LOG_POLY'(up);
    job_cfg = cfg; job_q = q; job_mont = mont; job_valid = 1'b1;
    @(negedge clk);
    while (!job_ready && k < 50) begin @(negedge clk); k++; end
    if (!job_ready) reportUnexpected("accept_timeout", 64'(k));
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic feedLoad(input int poly, input logic [31:0] base, input int gap);
    logic [31:0] d;
    for (int i = 0; i < N; i++) begin
      if (i > 0) repeat (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
      d = base + 32'(i);
      in_valid = 1'b1; in_data = d;
      refMem[poly][i] = d;
      expWrAddr.push_back(20'((poly << LOGN) | i));
      expWrData.push_back(64'(d));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic waitCmd(input logic [7:0] which);
    int k = 0;
    @(negedge clk);
    while (!(command_we && command_in == which) && k < 100) begin @(negedge clk); k++; end
    if (k >= 100) reportUnexpected("cmd_timeout", 64'(which));
  endtask

  task automatic waitIdle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 200) begin @(negedge clk); k++; end
    if (busy) reportUnexpected("idle_timeout", 64'(k));
  endtask

  initial begin
    int c;
    int run;
    logic sawIo;
    rst_n = 1'b0; job_valid = 1'b0; job_cfg = '0; job_q = '0; job_mont = '0;
    job_load_en = 1'b0; job_unload_en = 1'b0; job_load_poly = '0; job_unload_poly = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1; done_ins_computation = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_job_ready", 64'(job_ready), 0);
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_grant", 64'(grant_ext_io), 0);
    checkOutput("rst_cmd_we", 64'(command_we), 0);
    checkOutput("rst_dina", dina_ext, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rel_job_ready", 64'(job_ready), 1);
    checkOutput("rel_grant", 64'(grant_ext_io), 1);

    // Abort mid-LOAD at beat 3
    applyStimulus(1'b1, 1'b0, 0, 0, 32'h3, 32'h11, 32'h22);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h100 + 32'(i);
      expWrAddr.push_back(20'(i));
      expWrData.push_back(64'(32'h100 + 32'(i)));
      @(posedge clk); #1;
    end
    rst_n = 1'b0; in_data = 32'h103; in_valid = 1'b1;
    @(negedge clk);
    checkOutput("abort_wea", 64'(wea_ext), 0);
    checkOutput("abort_cmd_we", 64'(command_we), 0);
    checkOutput("abort_out_valid", 64'(out_valid), 0);
    checkOutput("abort_busy", 64'(busy), 0);
    checkOutput("abort_grant", 64'(grant_ext_io), 0);
    @(posedge clk); #1 in_valid = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("abort_rel_job_ready", 64'(job_ready), 1);
    checkOutput("abort_rel_grant", 64'(grant_ext_io), 1);

    // Full job: load poly 1 with 1..8, run, unload poly 1
    expCmd.push_back(8'h80); expCmd.push_back(8'h00);
    applyStimulus(1'b1, 1'b1, 1, 1, 32'h0000_0005, 32'h7FFF_E001, 32'h0000_1234);
    feedLoad(1, 32'd1, 0);
    @(negedge clk);
    checkOutput("arm_dina", dina_ext, 64'h7FFF_E001);
    checkOutput("arm_dina2", 64'(dina2_ext), 64'h5);
    checkOutput("arm_dina3", dina3_ext, 64'h1234);
    checkOutput("arm_cmd_we", 64'(command_we), 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("run_cmd_we", 64'(command_we), 1);
    checkOutput("run_cmd_in", 64'(command_in), 64'h80);
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1 done_ins_computation = 1'b1;
    for (int i = 0; i < N; i++) expOut.push_back(refMem[1][i]);
    waitCmd(8'h00);
    @(posedge clk); #1 done_ins_computation = 1'b0;
    @(negedge clk);
    checkOutput("unload_addr0", 64'(address_ext), 64'h08);
    c = 0;
    while (!out_valid && c < 20) begin @(negedge clk); c++; end
    checkOutput("first_out_latency", 64'(c), 64'(RD_LAT + 1));
    run = 0;
    while (out_valid && run < 20) begin run++; @(negedge clk); end
    checkOutput("out_burst_len", 64'(run), 64'(N));
    waitIdle();
    checkOutput("full_out_left", 64'(expOut.size()), 0);

    // Load stalls (1,0,0,1...) and unload backpressure
    expCmd.push_back(8'h80); expCmd.push_back(8'h00);
    applyStimulus(1'b1, 1'b1, 2, 2, 32'h0000_0009, 32'h0000_3001, 32'h0000_0077);
    feedLoad(2, 32'hC0DE_0100, 2);
    waitCmd(8'h80);
    @(posedge clk); #1 done_ins_computation = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < N; i++) expOut.push_back(refMem[2][i]);
    waitCmd(8'h00);
    @(posedge clk); #1 done_ins_computation = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_addr", 64'(address_ext), 64'h13);
    checkOutput("stall_out_valid", 64'(out_valid), 1);
    checkOutput("stall_out_pending", 64'(expOut.size()), 64'(N));
    @(posedge clk); #1 out_ready = 1'b1;
    waitIdle();
    checkOutput("stall_out_left", 64'(expOut.size()), 0);
    checkOutput("wr_left", 64'(expWrAddr.size()), 0);

    // Compute-only job with done already high, then a back-to-back job
    done_ins_computation = 1'b1;
    expCmd.push_back(8'h80); expCmd.push_back(8'h00);
    expCmd.push_back(8'h80); expCmd.push_back(8'h00);
    @(posedge clk); #1;
    job_load_en = 1'b0; job_unload_en = 1'b0; job_load_poly = '0; job_unload_poly = '0;
    job_cfg = 32'h11; job_q = 32'h101; job_mont = 32'h1; job_valid = 1'b1;
    c = 0;
    @(negedge clk);
    while (!job_ready && c < 50) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    job_cfg = 32'h22; job_q = 32'h202;
    @(negedge clk);
    checkOutput("a_dina", dina_ext, 64'h101);
    checkOutput("a_dina2", 64'(dina2_ext), 64'h11);
    run = 0; sawIo = 1'b0;
    while (busy && run < 20) begin
      sawIo = sawIo | in_ready | out_valid;
      run++;
      @(negedge clk);
    end
    checkOutput("compute_busy_cycles", 64'(run), 4);
    checkOutput("compute_no_io", 64'(sawIo), 0);
    checkOutput("b2b_job_ready", 64'(job_ready), 1);
    @(posedge clk); #1 job_valid = 1'b0;
    @(negedge clk);
    checkOutput("b_busy", 64'(busy), 1);
    checkOutput("b_dina", dina_ext, 64'h202);
    checkOutput("b_dina2", 64'(dina2_ext), 64'h22);
    waitIdle();
    done_ins_computation = 1'b0;
    checkOutput("cmd_left", 64'(expCmd.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
